// File: rtl/regfile_dbg_pkg.sv
// rtl/regfile_dbg_pkg.sv - shared op encodings, state enum and width defaults for the regfile debug port
package regfile_dbg_pkg;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_SEL_W  = 2;

   localparam logic [1:0] OP_NOP   = 2'b00;
   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] OP_READ  = 2'b10;
   localparam logic [1:0] OP_DUMP  = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR,
      ST_RD_SEL,
      ST_EMIT_A,
      ST_EMIT_B
   } state_t;

endpackage

// File: rtl/regfile_debug_port.sv
// rtl/regfile_debug_port.sv - command-driven initiator that writes, reads and dumps the 4x8 register file
module regfile_debug_port
   import regfile_dbg_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int SEL_W  = DEF_SEL_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [SEL_W-1:0]  cmd_reg_a,
   input  logic [SEL_W-1:0]  cmd_reg_b,
   input  logic [DATA_W-1:0] cmd_data,
   output logic              rf_write_en,
   output logic [SEL_W-1:0]  rf_write_sel,
   output logic [DATA_W-1:0] rf_input_data,
   output logic [SEL_W-1:0]  rf_port_a_sel,
   output logic [SEL_W-1:0]  rf_port_b_sel,
   input  logic [DATA_W-1:0] rf_port_a_data,
   input  logic [DATA_W-1:0] rf_port_b_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic              busy
);

   state_t              state_q, state_d;
   logic [1:0]          op_q;
   logic [SEL_W-1:0]    reg_a_q, reg_b_q;
   logic [DATA_W-1:0]   data_q, buf_a_q, buf_b_q;
   logic                p_q;
   logic                last_pair;

   // A READ is a single pair; a DUMP finishes on its second pair.
   assign last_pair = (op_q != OP_DUMP) || p_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         op_q    <= OP_NOP;
         reg_a_q <= '0;
         reg_b_q <= '0;
         data_q  <= '0;
         p_q     <= 1'b0;
         buf_a_q <= '0;
         buf_b_q <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            ST_IDLE: begin
               if (cmd_valid) begin
                  op_q    <= cmd_op;
                  reg_a_q <= cmd_reg_a;
                  reg_b_q <= cmd_reg_b;
                  data_q  <= cmd_data;
                  p_q     <= 1'b0;
               end
            end
            ST_RD_SEL: begin
               buf_a_q <= rf_port_a_data;
               buf_b_q <= rf_port_b_data;
            end
            ST_EMIT_B: begin
               if (out_ready && !last_pair) p_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               case (cmd_op)
                  OP_WRITE: state_d = ST_WR;
                  OP_READ:  state_d = ST_RD_SEL;
                  OP_DUMP:  state_d = ST_RD_SEL;
                  default:  state_d = ST_IDLE;
               endcase
            end
         end
         ST_WR:     state_d = ST_IDLE;
         ST_RD_SEL: state_d = ST_EMIT_A;
         ST_EMIT_A: if (out_ready) state_d = ST_EMIT_B;
         ST_EMIT_B: if (out_ready) state_d = last_pair ? ST_IDLE : ST_RD_SEL;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Outputs are gated by reset so nothing leaks out during the reset cycle itself.
   always_comb begin
      cmd_ready     = 1'b0;
      rf_write_en   = 1'b0;
      rf_write_sel  = '0;
      rf_input_data = '0;
      rf_port_a_sel = '0;
      rf_port_b_sel = '0;
      out_valid     = 1'b0;
      out_data      = '0;
      out_last      = 1'b0;
      busy          = 1'b0;
      if (reset) begin
         busy = (state_q != ST_IDLE);
         case (state_q)
            ST_IDLE: cmd_ready = 1'b1;
            ST_WR: begin
               rf_write_en   = 1'b1;
               rf_write_sel  = reg_a_q;
               rf_input_data = data_q;
            end
            ST_RD_SEL: begin
               if (op_q == OP_DUMP) begin
                  rf_port_a_sel = SEL_W'({p_q, 1'b0});
                  rf_port_b_sel = SEL_W'({p_q, 1'b1});
               end else begin
                  rf_port_a_sel = reg_a_q;
                  rf_port_b_sel = reg_b_q;
               end
            end
            ST_EMIT_A: begin
               out_valid = 1'b1;
               out_data  = buf_a_q;
            end
            ST_EMIT_B: begin
               out_valid = 1'b1;
               out_data  = buf_b_q;
               out_last  = last_pair;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_debug_port.sv
// tb/tb_regfile_debug_port.sv - self-checking bench for regfile_debug_port against a behavioural register file
module tb_regfile_debug_port;
   import regfile_dbg_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_op;
   logic [1:0] cmd_reg_a, cmd_reg_b;
   logic [7:0] cmd_data;
   logic       rf_write_en;
   logic [1:0] rf_write_sel;
   logic [7:0] rf_input_data;
   logic [1:0] rf_port_a_sel, rf_port_b_sel;
   logic [7:0] rf_port_a_data, rf_port_b_data;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic       out_last;
   logic       busy;

   logic [7:0] rf [4];
   logic       rf_clr;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   regfile_debug_port #(.DATA_W(8), .SEL_W(2)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_reg_a(cmd_reg_a), .cmd_reg_b(cmd_reg_b), .cmd_data(cmd_data),
      .rf_write_en(rf_write_en), .rf_write_sel(rf_write_sel), .rf_input_data(rf_input_data),
      .rf_port_a_sel(rf_port_a_sel), .rf_port_b_sel(rf_port_b_sel),
      .rf_port_a_data(rf_port_a_data), .rf_port_b_data(rf_port_b_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_last(out_last), .busy(busy)
   );

   // Behavioural 4x8 register file: registered write, combinational reads.
   always @(posedge clk) begin
      if (rf_clr) begin
         for (int i = 0; i < 4; i++) rf[i] <= 8'h00;
      end else if (rf_write_en) begin
         rf[rf_write_sel] <= rf_input_data;
      end
   end
   assign rf_port_a_data = rf[rf_port_a_sel];
   assign rf_port_b_data = rf[rf_port_b_sel];

   task automatic chkb(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0b required=%0b", name, act, exp);
      end
   endtask

   task automatic chkv(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%02h required=%02h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offers one command and returns in the cycle right after the accepting edge.
   task automatic issue(input logic [1:0] op, input logic [1:0] a, input logic [1:0] b, input logic [7:0] d);
      int n;
      n = 0;
      while (!cmd_ready && n < 8) begin
         step();
         n++;
      end
      chkb("issue_ready", cmd_ready, 1'b1);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_reg_a = a;
      cmd_reg_b = b;
      cmd_data  = d;
      step();
      cmd_valid = 1'b0;
   endtask

   // Called in the RD_SEL cycle with out_ready high; collects nb bytes then checks the return to IDLE.
   task automatic collect(input string name, input int nb, input logic [31:0] bytes, input logic [3:0] lastm);
      int w;
      for (int k = 0; k < nb; k++) begin
         w = 0;
         step();
         while (!out_valid && w < 4) begin
            step();
            w++;
         end
         chkb({name, "_valid"}, out_valid, 1'b1);
         chkv({name, "_data"}, out_data, bytes[k*8 +: 8]);
         chkb({name, "_last"}, out_last, lastm[k]);
         if (k == 0) chkb({name, "_first_latency"}, (w == 0), 1'b1);
      end
      step();
      chkb({name, "_end_busy"}, busy, 1'b0);
      chkb({name, "_end_ready"}, cmd_ready, 1'b1);
      chkb({name, "_end_valid"}, out_valid, 1'b0);
   endtask

   typedef struct {
      logic [1:0]  op;
      logic [1:0]  a;
      logic [1:0]  b;
      logic [7:0]  d;
      int          nb;
      logic [31:0] bytes;
      logic [3:0]  lastm;
   } vec_t;

   vec_t vt [9];

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      vt[0] = '{OP_WRITE, 2'd2, 2'd0, 8'hA5, 0, 32'h0, 4'b0000};
      vt[1] = '{OP_READ,  2'd2, 2'd2, 8'h00, 2, 32'h0000A5A5, 4'b0010};
      vt[2] = '{OP_WRITE, 2'd0, 2'd0, 8'h11, 0, 32'h0, 4'b0000};
      vt[3] = '{OP_WRITE, 2'd1, 2'd0, 8'h22, 0, 32'h0, 4'b0000};
      vt[4] = '{OP_WRITE, 2'd2, 2'd0, 8'h33, 0, 32'h0, 4'b0000};
      vt[5] = '{OP_WRITE, 2'd3, 2'd0, 8'h44, 0, 32'h0, 4'b0000};
      vt[6] = '{OP_DUMP,  2'd0, 2'd0, 8'h00, 4, 32'h44332211, 4'b1000};
      vt[7] = '{OP_READ,  2'd0, 2'd3, 8'h00, 2, 32'h00004411, 4'b0010};
      vt[8] = '{OP_NOP,   2'd3, 2'd3, 8'hFF, 0, 32'h0, 4'b0000};

      reset = 1'b0; rf_clr = 1'b1; out_ready = 1'b1;
      cmd_valid = 1'b0; cmd_op = OP_NOP; cmd_reg_a = 2'd0; cmd_reg_b = 2'd0; cmd_data = 8'h00;
      step();
      step();
      chkb("rst_cmd_ready", cmd_ready, 1'b0);
      chkb("rst_busy", busy, 1'b0);
      chkb("rst_out_valid", out_valid, 1'b0);
      chkb("rst_write_en", rf_write_en, 1'b0);
      rf_clr = 1'b0;
      reset  = 1'b1;
      #1;
      chkb("post_rst_ready", cmd_ready, 1'b1);
      chkb("post_rst_busy", busy, 1'b0);

      for (int i = 0; i < 9; i++) begin
         issue(vt[i].op, vt[i].a, vt[i].b, vt[i].d);
         case (vt[i].op)
            OP_WRITE: begin
               chkb("wr_en", rf_write_en, 1'b1);
               chkv("wr_sel", 8'(rf_write_sel), 8'(vt[i].a));
               chkv("wr_data", rf_input_data, vt[i].d);
               chkb("wr_busy", busy, 1'b1);
               chkb("wr_ready", cmd_ready, 1'b0);
               step();
               chkb("wr_en_one_cycle", rf_write_en, 1'b0);
               chkb("wr_ready_again", cmd_ready, 1'b1);
            end
            OP_NOP: begin
               chkb("nop_ready", cmd_ready, 1'b1);
               chkb("nop_busy", busy, 1'b0);
               chkb("nop_wr", rf_write_en, 1'b0);
               chkb("nop_valid", out_valid, 1'b0);
            end
            default: begin
               chkb("rd_sel_busy", busy, 1'b1);
               chkb("rd_sel_valid", out_valid, 1'b0);
               chkv("rd_sel_a", 8'(rf_port_a_sel), (vt[i].op == OP_DUMP) ? 8'd0 : 8'(vt[i].a));
               chkv("rd_sel_b", 8'(rf_port_b_sel), (vt[i].op == OP_DUMP) ? 8'd1 : 8'(vt[i].b));
               collect("vec", vt[i].nb, vt[i].bytes, vt[i].lastm);
            end
         endcase
      end

      // Backpressure: READ(3,1) held off for five cycles.
      out_ready = 1'b0;
      issue(OP_READ, 2'd3, 2'd1, 8'h00);
      step();
      for (int i = 0; i < 5; i++) begin
         chkb("bp_valid", out_valid, 1'b1);
         chkv("bp_data", out_data, 8'h44);
         chkb("bp_last", out_last, 1'b0);
         step();
      end
      out_ready = 1'b1;
      chkv("bp_release_a", out_data, 8'h44);
      step();
      chkv("bp_b_data", out_data, 8'h22);
      chkb("bp_b_last", out_last, 1'b1);
      step();
      chkb("bp_idle", busy, 1'b0);

      // NOP held valid for several cycles: no activity.
      cmd_valid = 1'b1; cmd_op = OP_NOP;
      for (int i = 0; i < 3; i++) begin
         step();
         chkb("nop_hold_ready", cmd_ready, 1'b1);
         chkb("nop_hold_busy", busy, 1'b0);
         chkb("nop_hold_wr", rf_write_en, 1'b0);
         chkb("nop_hold_valid", out_valid, 1'b0);
      end

      // Back-to-back with cmd_valid held: WRITE r1=5A then READ(1,1).
      cmd_op = OP_WRITE; cmd_reg_a = 2'd1; cmd_reg_b = 2'd0; cmd_data = 8'h5A;
      chkb("b2b_ready0", cmd_ready, 1'b1);
      step();
      cmd_op = OP_READ; cmd_reg_a = 2'd1; cmd_reg_b = 2'd1; cmd_data = 8'h00;
      chkb("b2b_ready_wr", cmd_ready, 1'b0);
      chkb("b2b_wr_en", rf_write_en, 1'b1);
      chkv("b2b_wr_data", rf_input_data, 8'h5A);
      chkv("b2b_wr_sel", 8'(rf_write_sel), 8'd1);
      step();
      chkb("b2b_ready_idle", cmd_ready, 1'b1);
      chkb("b2b_wr_off", rf_write_en, 1'b0);
      step();
      cmd_valid = 1'b0;
      chkb("b2b_rd_busy", busy, 1'b1);
      collect("b2b", 2, 32'h00005A5A, 4'b0010);

      // Reset during DUMP while the third byte is pending.
      issue(OP_DUMP, 2'd0, 2'd0, 8'h00);
      step();
      chkv("rdump_b0", out_data, 8'h11);
      step();
      chkv("rdump_b1", out_data, 8'h5A);
      chkb("rdump_b1_last", out_last, 1'b0);
      step();
      out_ready = 1'b0;
      step();
      chkb("rdump_b2_valid", out_valid, 1'b1);
      chkv("rdump_b2_data", out_data, 8'h33);
      reset = 1'b0;
      #1;
      chkb("rdump_rst_valid", out_valid, 1'b0);
      chkb("rdump_rst_last", out_last, 1'b0);
      chkv("rdump_rst_data", out_data, 8'h00);
      chkb("rdump_rst_ready", cmd_ready, 1'b0);
      chkb("rdump_rst_busy", busy, 1'b0);
      step();
      chkb("rdump_rst2_valid", out_valid, 1'b0);
      chkb("rdump_rst2_ready", cmd_ready, 1'b0);
      reset = 1'b1;
      #1;
      chkb("rdump_rel_ready", cmd_ready, 1'b1);
      chkb("rdump_rel_busy", busy, 1'b0);
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chkb("rdump_no_bytes", out_valid, 1'b0);
      end

      // Reset in the WR cycle suppresses the strobe; register 0 keeps 0x11.
      issue(OP_WRITE, 2'd0, 2'd0, 8'hEE);
      reset = 1'b0;
      #1;
      chkb("rwr_no_strobe", rf_write_en, 1'b0);
      step();
      reset = 1'b1;
      #1;
      chkb("rwr_rel_ready", cmd_ready, 1'b1);
      issue(OP_READ, 2'd0, 2'd0, 8'h00);
      collect("rwr", 2, 32'h00001111, 4'b0010);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
